// File: rtl/solver_pool.sv
// rtl/solver_pool.sv - job dispatcher and round-robin result collector for a solver array
//
// Accepts multi-beat pixel jobs (tag + C limbs), loads each job into the lowest
// free solver channel, pulses that solver's start, and returns {tag, iterations}
// on a valid/ready result stream, picking finished channels round-robin.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cfg_wr_i / cfg_ready_o    config write request / accepted this cycle
//   cfg_num_limbs_i           limbs per C component
//   cfg_iter_lim_i            iteration limit
//   job_valid_i / job_ready_o job beat handshake
//   job_tag_i                 tag, sampled on the first beat of a job
//   job_re_i / job_im_i       real / imag limb of the current beat
//   s_wr_real_en_o/imag_en_o  per-solver limb write enables
//   s_wr_index_o              shared limb index
//   s_real_data_o/imag_data_o shared limb data
//   s_wr_num_limbs_en_o, s_num_limbs_data_o   broadcast num_limbs write
//   s_wr_iter_lim_en_o,  s_iter_lim_data_o    broadcast iteration limit write
//   s_start_o                 one-cycle start pulse per solver
//   s_out_ready_i             per-solver finished level
//   s_iterations_i            solver i count at [16*i +: 16]
//   res_valid_o / res_ready_i result handshake
//   res_tag_o, res_iterations_o  result payload
//   idle_o                    nothing loaded, running, finished or pending

module solver_pool #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27,
    parameter int TAG_BITS        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cfg_wr_i,
    output logic                        cfg_ready_o,
    input  logic [LIMB_INDEX_BITS-1:0]  cfg_num_limbs_i,
    input  logic [15:0]                 cfg_iter_lim_i,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [TAG_BITS-1:0]         job_tag_i,
    input  logic [LIMB_SIZE_BITS-1:0]   job_re_i,
    input  logic [LIMB_SIZE_BITS-1:0]   job_im_i,
    output logic [NUM_SOLVERS-1:0]      s_wr_real_en_o,
    output logic [NUM_SOLVERS-1:0]      s_wr_imag_en_o,
    output logic [LIMB_INDEX_BITS-1:0]  s_wr_index_o,
    output logic [LIMB_SIZE_BITS-1:0]   s_real_data_o,
    output logic [LIMB_SIZE_BITS-1:0]   s_imag_data_o,
    output logic [NUM_SOLVERS-1:0]      s_wr_num_limbs_en_o,
    output logic [LIMB_INDEX_BITS-1:0]  s_num_limbs_data_o,
    output logic [NUM_SOLVERS-1:0]      s_wr_iter_lim_en_o,
    output logic [15:0]                 s_iter_lim_data_o,
    output logic [NUM_SOLVERS-1:0]      s_start_o,
    input  logic [NUM_SOLVERS-1:0]      s_out_ready_i,
    input  logic [16*NUM_SOLVERS-1:0]   s_iterations_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [TAG_BITS-1:0]         res_tag_o,
    output logic [15:0]                 res_iterations_o,
    output logic                        idle_o
);

    localparam int IW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    localparam logic [2:0] ST_FREE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_ARM   = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]                 st_q   [NUM_SOLVERS];
    logic [2:0]                 st_d   [NUM_SOLVERS];
    logic [TAG_BITS-1:0]        tag_q  [NUM_SOLVERS];
    logic [TAG_BITS-1:0]        tag_d  [NUM_SOLVERS];
    logic [15:0]                iter_q [NUM_SOLVERS];
    logic [15:0]                iter_d [NUM_SOLVERS];

    logic                       load_active_q, load_active_d;
    logic [IW-1:0]              load_ch_q, load_ch_d;
    logic [LIMB_INDEX_BITS-1:0] beat_q, beat_d;
    logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_d;
    logic [15:0]                iter_lim_q, iter_lim_d;
    logic                       cfg_pulse_q, cfg_pulse_d;
    logic                       res_valid_q, res_valid_d;
    logic [TAG_BITS-1:0]        res_tag_q, res_tag_d;
    logic [15:0]                res_iter_q, res_iter_d;
    logic [IW-1:0]              rr_q, rr_d;

    logic                       any_free, all_free, all_free_or_done;
    logic [IW-1:0]              free_ch, cur_ch, win_ch;
    logic                       win_found, res_load;
    logic                       cfg_fire, job_fire, last_beat;
    logic [LIMB_INDEX_BITS-1:0] cur_beat, eff_limbs;

    // Channel occupancy summary; free_ch is the lowest-index FREE channel.
    always_comb begin
        any_free         = 1'b0;
        all_free         = 1'b1;
        all_free_or_done = 1'b1;
        free_ch          = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_ch  = IW'(i);
            end else begin
                all_free = 1'b0;
            end
            if (st_q[i] != ST_FREE && st_q[i] != ST_DONE) begin
                all_free_or_done = 1'b0;
            end
        end
    end

    // First DONE channel at or after the round-robin pointer.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_ch    = '0;
        for (int off = 0; off < NUM_SOLVERS; off++) begin
            idx = (int'(rr_q) + off) % NUM_SOLVERS;
            if (!win_found && st_q[idx] == ST_DONE) begin
                win_found = 1'b1;
                win_ch    = IW'(idx);
            end
        end
    end

    assign cfg_ready_o = !load_active_q && all_free_or_done;
    assign cfg_fire    = cfg_wr_i && cfg_ready_o;
    // A config write cycle steals the cycle from the job stream.
    assign job_ready_o = !cfg_wr_i && (load_active_q || any_free);
    assign job_fire    = job_valid_i && job_ready_o;
    assign cur_ch      = load_active_q ? load_ch_q : free_ch;
    assign cur_beat    = load_active_q ? beat_q : '0;
    // num_limbs of 0 behaves like a single-limb job.
    assign eff_limbs   = (num_limbs_q == '0) ? LIMB_INDEX_BITS'(1) : num_limbs_q;
    assign last_beat   = (cur_beat == eff_limbs - LIMB_INDEX_BITS'(1));
    assign res_load    = win_found && (!res_valid_q || res_ready_i);

    always_comb begin
        st_d          = st_q;
        tag_d         = tag_q;
        iter_d        = iter_q;
        load_active_d = load_active_q;
        load_ch_d     = load_ch_q;
        beat_d        = beat_q;
        num_limbs_d   = num_limbs_q;
        iter_lim_d    = iter_lim_q;
        cfg_pulse_d   = cfg_fire;
        res_valid_d   = res_valid_q;
        res_tag_d     = res_tag_q;
        res_iter_d    = res_iter_q;
        rr_d          = rr_q;

        for (int i = 0; i < NUM_SOLVERS; i++) begin
            case (st_q[i])
                ST_START: st_d[i] = ST_ARM;
                // ARM gives the solver a cycle to drop its stale out_ready.
                ST_ARM:   st_d[i] = ST_RUN;
                ST_RUN: begin
                    if (s_out_ready_i[i]) begin
                        st_d[i]   = ST_DONE;
                        iter_d[i] = s_iterations_i[16*i +: 16];
                    end
                end
                default: ;
            endcase
        end

        if (job_fire) begin
            if (!load_active_q) begin
                tag_d[cur_ch] = job_tag_i;
            end
            if (last_beat) begin
                st_d[cur_ch]  = ST_START;
                load_active_d = 1'b0;
                beat_d        = '0;
            end else begin
                st_d[cur_ch]  = ST_LOAD;
                load_active_d = 1'b1;
                load_ch_d     = cur_ch;
                beat_d        = cur_beat + LIMB_INDEX_BITS'(1);
            end
        end

        // The winner is always DONE, so it never collides with the loading channel.
        if (res_load) begin
            res_valid_d  = 1'b1;
            res_tag_d    = tag_q[win_ch];
            res_iter_d   = iter_q[win_ch];
            st_d[win_ch] = ST_FREE;
            if (int'(win_ch) == NUM_SOLVERS - 1) begin
                rr_d = '0;
            end else begin
                rr_d = win_ch + IW'(1);
            end
        end else if (res_ready_i) begin
            res_valid_d = 1'b0;
        end

        if (cfg_fire) begin
            num_limbs_d = cfg_num_limbs_i;
            iter_lim_d  = cfg_iter_lim_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                st_q[i]   <= ST_FREE;
                tag_q[i]  <= '0;
                iter_q[i] <= '0;
            end
            load_active_q <= 1'b0;
            load_ch_q     <= '0;
            beat_q        <= '0;
            num_limbs_q   <= LIMB_INDEX_BITS'(1);
            iter_lim_q    <= '0;
            cfg_pulse_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_tag_q     <= '0;
            res_iter_q    <= '0;
            rr_q          <= '0;
        end else begin
            st_q          <= st_d;
            tag_q         <= tag_d;
            iter_q        <= iter_d;
            load_active_q <= load_active_d;
            load_ch_q     <= load_ch_d;
            beat_q        <= beat_d;
            num_limbs_q   <= num_limbs_d;
            iter_lim_q    <= iter_lim_d;
            cfg_pulse_q   <= cfg_pulse_d;
            res_valid_q   <= res_valid_d;
            res_tag_q     <= res_tag_d;
            res_iter_q    <= res_iter_d;
            rr_q          <= rr_d;
        end
    end

    // Limb writes go out in the handshake cycle itself.
    always_comb begin
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            s_wr_real_en_o[i] = job_fire && (int'(cur_ch) == i);
            s_wr_imag_en_o[i] = job_fire && (int'(cur_ch) == i);
            s_start_o[i]      = (st_q[i] == ST_START);
        end
    end

    assign s_wr_index_o  = job_fire ? cur_beat : '0;
    assign s_real_data_o = job_fire ? job_re_i : '0;
    assign s_imag_data_o = job_fire ? job_im_i : '0;

    // Config broadcast is driven from the stored registers the cycle after the write.
    assign s_wr_num_limbs_en_o = {NUM_SOLVERS{cfg_pulse_q}};
    assign s_wr_iter_lim_en_o  = {NUM_SOLVERS{cfg_pulse_q}};
    assign s_num_limbs_data_o  = cfg_pulse_q ? num_limbs_q : '0;
    assign s_iter_lim_data_o   = cfg_pulse_q ? iter_lim_q : '0;

    assign res_valid_o      = res_valid_q;
    assign res_tag_o        = res_tag_q;
    assign res_iterations_o = res_iter_q;
    assign idle_o           = all_free && !load_active_q && !res_valid_q;

endmodule

// File: tb/tb_solver_pool.sv
// tb/tb_solver_pool.sv - scoreboard bench for solver_pool
module tb_solver_pool;

    localparam int N   = 4;
    localparam int LIB = 6;
    localparam int LSB = 27;
    localparam int TB  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_wr, cfg_ready;
    logic [LIB-1:0]   cfg_num_limbs;
    logic [15:0]      cfg_iter_lim;
    logic             job_valid, job_ready;
    logic [TB-1:0]    job_tag;
    logic [LSB-1:0]   job_re, job_im;
    logic [N-1:0]     s_wr_real_en, s_wr_imag_en;
    logic [LIB-1:0]   s_wr_index;
    logic [LSB-1:0]   s_real_data, s_imag_data;
    logic [N-1:0]     s_wr_num_limbs_en, s_wr_iter_lim_en;
    logic [LIB-1:0]   s_num_limbs_data;
    logic [15:0]      s_iter_lim_data;
    logic [N-1:0]     s_start, s_out_ready;
    logic [16*N-1:0]  s_iterations;
    logic             res_valid, res_ready;
    logic [TB-1:0]    res_tag;
    logic [15:0]      res_iter;
    logic             idle;

    always #5 clk = ~clk;

    solver_pool #(
        .NUM_SOLVERS(N), .LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB), .TAG_BITS(TB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_wr_i(cfg_wr), .cfg_ready_o(cfg_ready),
        .cfg_num_limbs_i(cfg_num_limbs), .cfg_iter_lim_i(cfg_iter_lim),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_tag_i(job_tag),
        .job_re_i(job_re), .job_im_i(job_im),
        .s_wr_real_en_o(s_wr_real_en), .s_wr_imag_en_o(s_wr_imag_en),
        .s_wr_index_o(s_wr_index), .s_real_data_o(s_real_data), .s_imag_data_o(s_imag_data),
        .s_wr_num_limbs_en_o(s_wr_num_limbs_en), .s_num_limbs_data_o(s_num_limbs_data),
        .s_wr_iter_lim_en_o(s_wr_iter_lim_en), .s_iter_lim_data_o(s_iter_lim_data),
        .s_start_o(s_start), .s_out_ready_i(s_out_ready), .s_iterations_i(s_iterations),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_tag_o(res_tag), .res_iterations_o(res_iter), .idle_o(idle)
    );

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] it;
    } res_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is popped against the scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got tag 0x%0h iter %0d, none expected", res_tag, res_iter);
            end else begin
                e = exp_q.pop_front();
                check("res_tag", 64'(res_tag), 64'(e.tag));
                check("res_iter", 64'(res_iter), 64'(e.it));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        job_valid = 1'b0;
        cfg_wr    = 1'b0;
        s_out_ready = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_start", 64'(s_start), 64'd0);
        check("rst_cfg_en", 64'({s_wr_num_limbs_en, s_wr_iter_lim_en}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_cfg(input logic [LIB-1:0] nl, input logic [15:0] lim);
        cfg_wr        = 1'b1;
        cfg_num_limbs = nl;
        cfg_iter_lim  = lim;
        @(negedge clk);
        check("cfg_ready", 64'(cfg_ready), 64'd1);
        check("job_ready_in_cfg", 64'(job_ready), 64'd0);
        step();
        cfg_wr = 1'b0;
        @(negedge clk);
        check("cfg_nl_en", 64'(s_wr_num_limbs_en), 64'hF);
        check("cfg_il_en", 64'(s_wr_iter_lim_en), 64'hF);
        check("cfg_nl_data", 64'(s_num_limbs_data), 64'(nl));
        check("cfg_il_data", 64'(s_iter_lim_data), 64'(lim));
        step();
        @(negedge clk);
        check("cfg_en_clear", 64'({s_wr_num_limbs_en, s_wr_iter_lim_en}), 64'd0);
        step();
    endtask

    task automatic send_job(input logic [15:0] tag, input int n, input int ch, input int base);
        int w;
        for (int k = 0; k < n; k++) begin
            job_valid = 1'b1;
            job_tag   = tag;
            job_re    = LSB'(base + k);
            job_im    = LSB'(base + k + 100);
            w = 0;
            @(negedge clk);
            while (job_ready !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (job_ready !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL job_ready_timeout: tag 0x%0h beat %0d never accepted", tag, k);
                job_valid = 1'b0;
                return;
            end
            check("wr_index", 64'(s_wr_index), 64'(k));
            check("wr_real_en", 64'(s_wr_real_en), 64'(1 << ch));
            check("wr_imag_en", 64'(s_wr_imag_en), 64'(1 << ch));
            check("wr_real_data", 64'(s_real_data), 64'(base + k));
            check("wr_imag_data", 64'(s_imag_data), 64'(base + k + 100));
            step();
        end
        job_valid = 1'b0;
    endtask

    task automatic finish(input logic [N-1:0] mask, input logic [16*N-1:0] its);
        s_iterations = its;
        s_out_ready  = mask;
        step();
        s_out_ready  = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            step();
            w++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        cfg_wr = 0; cfg_num_limbs = '0; cfg_iter_lim = '0;
        job_valid = 0; job_tag = '0; job_re = '0; job_im = '0;
        s_out_ready = '0; s_iterations = '0; res_ready = 1'b0;

        // Reset and configuration broadcast
        do_reset();
        do_cfg(6'd3, 16'd100);

        // Single 3-beat job into ch0
        res_ready = 1'b1;
        send_job(16'h0042, 3, 0, 'h100);
        @(negedge clk);
        check("start_ch0", 64'(s_start), 64'h1);
        step();
        @(negedge clk);
        check("start_one_cycle", 64'(s_start), 64'h0);
        check("busy_not_idle", 64'(idle), 64'd0);
        step();
        exp_q.push_back('{tag: 16'h0042, it: 16'd57});
        finish(4'b0001, {16'd0, 16'd0, 16'd0, 16'd57});
        drain();

        // Fill all channels, then backpressure on the 5th job
        res_ready = 1'b0;
        for (int j = 0; j < 4; j++) send_job(16'(j + 1), 3, j, 'h200 + 16 * j);
        job_valid = 1'b1;
        job_tag   = 16'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("backpressure", 64'(job_ready), 64'd0);
            step();
        end
        job_valid = 1'b0;
        exp_q.push_back('{tag: 16'd1, it: 16'd10});
        finish(4'b0001, {16'd0, 16'd0, 16'd0, 16'd10});
        step();

        // Result held stable under res_ready=0
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_tag", 64'(res_tag), 64'd1);
            check("hold_iter", 64'(res_iter), 64'd10);
            check("hold_idle", 64'(idle), 64'd0);
            step();
        end
        send_job(16'd5, 3, 0, 'h280);
        res_ready = 1'b1;
        drain();

        // Simultaneous finish, round-robin order
        do_reset();
        do_cfg(6'd3, 16'd100);
        for (int j = 0; j < 4; j++) send_job(16'h0010 + 16'(j), 3, j, 'h300 + 16 * j);
        step();
        step();
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) exp_q.push_back('{tag: 16'h0010 + 16'(j), it: 16'd20 + 16'(j)});
        finish(4'b1111, {16'd23, 16'd22, 16'd21, 16'd20});
        drain();
        send_job(16'h0020, 3, 0, 'h400);
        send_job(16'h0021, 3, 1, 'h410);
        step();
        step();
        exp_q.push_back('{tag: 16'h0020, it: 16'd30});
        exp_q.push_back('{tag: 16'h0021, it: 16'd31});
        finish(4'b0011, {16'd0, 16'd0, 16'd31, 16'd30});
        drain();

        // Reset during the second beat of a load
        job_valid = 1'b1;
        job_tag   = 16'h0077;
        job_re    = '0;
        job_im    = '0;
        @(negedge clk);
        check("mid_first_beat_ready", 64'(job_ready), 64'd1);
        step();
        @(negedge clk);
        rst_n     = 1'b0;
        job_valid = 1'b0;
        #1;
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_wr_en", 64'(s_wr_real_en), 64'd0);
        check("mid_rst_start", 64'(s_start), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        // num_limbs is back to 1 after reset: single-beat job
        send_job(16'h0078, 1, 0, 'h500);
        @(negedge clk);
        check("post_rst_start", 64'(s_start), 64'h1);
        step();
        step();
        exp_q.push_back('{tag: 16'h0078, it: 16'd99});
        finish(4'b0001, {16'd0, 16'd0, 16'd0, 16'd99});
        drain();

        // num_limbs=0 behaves as a single beat
        do_cfg(6'd0, 16'd5);
        send_job(16'h0079, 1, 0, 'h600);
        @(negedge clk);
        check("nl0_start", 64'(s_start), 64'h1);
        step();
        step();
        exp_q.push_back('{tag: 16'h0079, it: 16'd5});
        finish(4'b0001, {16'd0, 16'd0, 16'd0, 16'd5});
        drain();

        @(negedge clk);
        check("final_idle", 64'(idle), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
